// File: rtl/micro_tile_scheduler.sv
// Sequencer for the shared micro-tile output mux: selects one tile at a time, holds a newly
// selected tile in reset for RST_CYCLES, then runs it (manual select or auto round-robin).
module micro_tile_scheduler #(
  parameter int NTILES     = 4,
  parameter int SEL_W      = 2,
  parameter int RST_CYCLES = 4,
  parameter int DWELL_W    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mode,
  input  logic [SEL_W-1:0]   man_sel,
  input  logic [NTILES-1:0]  tile_en,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               advance,
  output logic [SEL_W-1:0]   sel,
  output logic [NTILES-1:0]  tile_rst_n,
  output logic               out_valid,
  output logic               switch_pulse
);

  localparam int CNT_W = $clog2(RST_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    RESET_TILE = 2'd1,
    RUN        = 2'd2
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [DWELL_W-1:0] dwell_cnt;

  logic               load;
  logic [SEL_W-1:0]   load_tgt;
  logic [SEL_W-1:0]   next_tile;
  logic [DWELL_W-1:0] dwell_last;
  logic               decide;

  function automatic logic [SEL_W-1:0] lowest_enabled(input logic [NTILES-1:0] en);
    logic [SEL_W-1:0] r;
    r = '0;
    for (int i = NTILES - 1; i >= 0; i--) begin
      if (en[i]) r = SEL_W'(i);
    end
    return r;
  endfunction

  // First enabled tile after cur in increasing order with wrap; returns cur if no other is enabled.
  function automatic logic [SEL_W-1:0] next_enabled(input logic [SEL_W-1:0] cur,
                                                    input logic [NTILES-1:0] en);
    logic [SEL_W-1:0] r;
    logic [SEL_W-1:0] idx;
    r = cur;
    for (int k = NTILES - 1; k >= 1; k--) begin
      idx = cur + SEL_W'(k);
      if (en[idx]) r = idx;
    end
    return r;
  endfunction

  function automatic logic [NTILES-1:0] onehot(input logic [SEL_W-1:0] idx);
    logic [NTILES-1:0] r;
    r = '0;
    r[idx] = 1'b1;
    return r;
  endfunction

  assign dwell_last = (dwell == '0) ? '0 : dwell - DWELL_W'(1);
  assign next_tile  = next_enabled(sel, tile_en);
  // Advance and terminal count share one decision point, so they can never double-switch.
  assign decide     = advance || (dwell_cnt >= dwell_last);

  always_comb begin
    load     = 1'b0;
    load_tgt = sel;
    case (state)
      IDLE: begin
        if (!mode) begin
          load     = 1'b1;
          load_tgt = man_sel;
        end else if (|tile_en) begin
          load     = 1'b1;
          load_tgt = lowest_enabled(tile_en);
        end
      end
      RESET_TILE: begin
        if (!mode && (man_sel != sel)) begin
          load     = 1'b1;
          load_tgt = man_sel;
        end
      end
      RUN: begin
        if (!mode) begin
          if (man_sel != sel) begin
            load     = 1'b1;
            load_tgt = man_sel;
          end
        end else if ((|tile_en) && decide && (next_tile != sel)) begin
          load     = 1'b1;
          load_tgt = next_tile;
        end
      end
      default: begin
        load     = 1'b0;
        load_tgt = sel;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      sel          <= '0;
      cnt          <= '0;
      dwell_cnt    <= '0;
      switch_pulse <= 1'b0;
      out_valid    <= 1'b0;
      tile_rst_n   <= '0;
    end else begin
      switch_pulse <= 1'b0;
      if (load) begin
        state        <= RESET_TILE;
        sel          <= load_tgt;
        cnt          <= CNT_W'(RST_CYCLES - 1);
        switch_pulse <= 1'b1;
        out_valid    <= 1'b0;
        tile_rst_n   <= '0;
      end else begin
        case (state)
          IDLE: begin
            out_valid  <= 1'b0;
            tile_rst_n <= '0;
          end
          RESET_TILE: begin
            if (cnt == '0) begin
              state      <= RUN;
              dwell_cnt  <= '0;
              out_valid  <= 1'b1;
              tile_rst_n <= onehot(sel);
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
          RUN: begin
            if (mode) begin
              if (tile_en == '0) begin
                state      <= IDLE;
                out_valid  <= 1'b0;
                tile_rst_n <= '0;
              end else if (decide) begin
                dwell_cnt <= '0;
              end else begin
                dwell_cnt <= dwell_cnt + DWELL_W'(1);
              end
            end
          end
          default: begin
            state      <= IDLE;
            out_valid  <= 1'b0;
            tile_rst_n <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_micro_tile_scheduler.sv
// Directed bench for micro_tile_scheduler: manual select, auto round-robin, advance, idle and reset.
module tb_micro_tile_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       mode;
  logic [1:0] man_sel;
  logic [3:0] tile_en;
  logic [7:0] dwell;
  logic       advance;
  logic [1:0] sel;
  logic [3:0] tile_rst_n;
  logic       out_valid;
  logic       switch_pulse;

  int vectors    = 0;
  int miscompares = 0;

  micro_tile_scheduler #(.NTILES(4), .SEL_W(2), .RST_CYCLES(4), .DWELL_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .mode         (mode),
    .man_sel      (man_sel),
    .tile_en      (tile_en),
    .dwell        (dwell),
    .advance      (advance),
    .sel          (sel),
    .tile_rst_n   (tile_rst_n),
    .out_valid    (out_valid),
    .switch_pulse (switch_pulse)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks the switch cycle, the four reset cycles and run_cycles cycles of RUN on tile s.
  task automatic tile_slot(input logic [1:0] s, input int run_cycles);
    tick();
    chk("sw_pulse", {15'd0, switch_pulse}, 16'd1);
    chk("sw_sel", {14'd0, sel}, {14'd0, s});
    chk("sw_valid", {15'd0, out_valid}, 16'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_valid", {15'd0, out_valid}, 16'd0);
      chk("rst_rstn", {12'd0, tile_rst_n}, 16'd0);
      chk("rst_pulse", {15'd0, switch_pulse}, 16'd0);
    end
    for (int i = 0; i < run_cycles; i++) begin
      tick();
      chk("run_valid", {15'd0, out_valid}, 16'd1);
      chk("run_rstn", {12'd0, tile_rst_n}, 16'd1 << s);
      chk("run_sel", {14'd0, sel}, {14'd0, s});
      chk("run_pulse", {15'd0, switch_pulse}, 16'd0);
    end
  endtask

  initial begin
    rst = 1'b1; mode = 1'b0; man_sel = 2'd2; tile_en = 4'b0000; dwell = 8'd0; advance = 1'b0;
    tick();
    tick();
    chk("reset_sel", {14'd0, sel}, 16'd0);
    chk("reset_rstn", {12'd0, tile_rst_n}, 16'd0);
    chk("reset_valid", {15'd0, out_valid}, 16'd0);
    chk("reset_pulse", {15'd0, switch_pulse}, 16'd0);

    // Manual select of tile 2, then switch to tile 1.
    rst = 1'b0;
    tile_slot(2'd2, 2);
    man_sel = 2'd1;
    tile_slot(2'd1, 2);

    // Auto rotation over tiles 0,1,3 with dwell 3, including the 3->0 wrap.
    rst = 1'b1;
    tick();
    rst = 1'b0; mode = 1'b1; tile_en = 4'b1011; dwell = 8'd3;
    tile_slot(2'd0, 3);
    tile_slot(2'd1, 3);
    tile_slot(2'd3, 3);
    tile_slot(2'd0, 3);

    // Advance at dwell count 1 switches immediately.
    tile_slot(2'd1, 2);
    advance = 1'b1;
    tile_slot(2'd3, 0);
    advance = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("adv_run_valid", {15'd0, out_valid}, 16'd1);
    end
    // Advance coinciding with terminal count gives a single switch.
    advance = 1'b1;
    tick();
    chk("adv_tc_pulse", {15'd0, switch_pulse}, 16'd1);
    chk("adv_tc_sel", {14'd0, sel}, 16'd0);
    advance = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("adv_tc_single", {15'd0, switch_pulse}, 16'd0);
      chk("adv_tc_sel_hold", {14'd0, sel}, 16'd0);
    end

    // Single enabled tile with dwell 0: stays on tile 2, never re-switches.
    rst = 1'b1;
    tick();
    rst = 1'b0; tile_en = 4'b0100; dwell = 8'd0;
    tile_slot(2'd2, 8);

    // Removing every enable drops to IDLE.
    tile_en = 4'b0000;
    tick();
    chk("idle_valid", {15'd0, out_valid}, 16'd0);
    chk("idle_rstn", {12'd0, tile_rst_n}, 16'd0);
    chk("idle_sel_hold", {14'd0, sel}, 16'd2);
    tick();
    chk("idle_stay_pulse", {15'd0, switch_pulse}, 16'd0);

    // Reset in the middle of RESET_TILE.
    tile_en = 4'b1000;
    tick();
    chk("pre_rst_sel", {14'd0, sel}, 16'd3);
    chk("pre_rst_pulse", {15'd0, switch_pulse}, 16'd1);
    tick();
    rst = 1'b1;
    tick();
    chk("midrst_sel", {14'd0, sel}, 16'd0);
    chk("midrst_pulse", {15'd0, switch_pulse}, 16'd0);
    chk("midrst_valid", {15'd0, out_valid}, 16'd0);
    chk("midrst_rstn", {12'd0, tile_rst_n}, 16'd0);
    rst = 1'b0; tile_en = 4'b0000;
    tick();
    chk("post_rst_sel", {14'd0, sel}, 16'd0);
    chk("post_rst_pulse", {15'd0, switch_pulse}, 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
